// File: rtl/led_drv_pkg.sv
// Shared constants and channel-state type for the LED pulse driver.
package led_drv_pkg;

   localparam int unsigned TICK_COUNTS_1MS = 50000;
   localparam int unsigned DUR_W_DEFAULT   = 12;

   typedef enum logic {
      CH_IDLE   = 1'b0,
      CH_ACTIVE = 1'b1
   } ch_state_e;

endpackage : led_drv_pkg

// File: rtl/led_pulse_driver_if.sv
// Start-command bus from game logic to the LED pulse driver.
interface led_pulse_driver_if #(
   parameter int unsigned NUM_LEDS = 18,
   parameter int unsigned DUR_W    = 12
);
   localparam int unsigned IDX_W = $clog2(NUM_LEDS);

   logic             start;
   logic [IDX_W-1:0] start_idx;
   logic [DUR_W-1:0] duration_ms;

   modport master (output start, output start_idx, output duration_ms);
   modport slave  (input  start, input  start_idx, input  duration_ms);

endinterface : led_pulse_driver_if

// File: rtl/led_channel_timer.sv
// One LED channel: remaining-tick counter with load > clear > tick priority.
module led_channel_timer
   import led_drv_pkg::*;
#(
   parameter int unsigned DUR_W = DUR_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DUR_W-1:0] load_val,
   input  logic             clear,
   input  logic             tick,
   output logic             led,
   output logic             expired
);

   ch_state_e        state, state_nxt;
   logic [DUR_W-1:0] remaining, remaining_nxt;
   logic             led_nxt;
   logic             expired_nxt;

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CH_IDLE;
         remaining <= '0;
         led       <= 1'b0;
         expired   <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         led       <= led_nxt;
         expired   <= expired_nxt;
      end
   end

   // Next state: a load always wins, clear beats the tick decrement.
   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      if (load) begin
         state_nxt     = CH_ACTIVE;
         remaining_nxt = load_val;
      end else if (clear) begin
         state_nxt     = CH_IDLE;
         remaining_nxt = '0;
      end else if (tick && (state == CH_ACTIVE)) begin
         remaining_nxt = remaining - DUR_W'(1);
         if (remaining == DUR_W'(1)) begin
            state_nxt = CH_IDLE;
         end
      end
   end

   // Outputs: LED follows next state; expiry only on an undisturbed 1->0 tick.
   always_comb begin
      led_nxt     = 1'b0;
      expired_nxt = 1'b0;
      led_nxt     = (state_nxt == CH_ACTIVE);
      expired_nxt = !load && !clear && tick && (state == CH_ACTIVE)
                    && (remaining == DUR_W'(1));
   end

endmodule : led_channel_timer

// File: rtl/led_pulse_driver.sv
// Multi-channel timed LED driver with shared millisecond prescaler.
module led_pulse_driver
   import led_drv_pkg::*;
#(
   parameter int unsigned NUM_LEDS    = 18,
   parameter int unsigned TICK_COUNTS = TICK_COUNTS_1MS,
   parameter int unsigned DUR_W       = DUR_W_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   led_pulse_driver_if.slave   cmd,
   input  logic [NUM_LEDS-1:0] clear,
   output logic [NUM_LEDS-1:0] leds,
   output logic [NUM_LEDS-1:0] expired,
   output logic                tick
);

   localparam int unsigned IDX_W   = $clog2(NUM_LEDS);
   localparam int unsigned PRESC_W = $clog2(TICK_COUNTS) + 1;

   logic [PRESC_W-1:0]  presc;
   logic                start_ok_c;
   logic [NUM_LEDS-1:0] load_c;

   // Free-running prescaler; tick is registered one cycle after the wrap value.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc == PRESC_W'(TICK_COUNTS - 1)) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + PRESC_W'(1);
         tick  <= 1'b0;
      end
   end

   // A start is only honoured for an existing channel and a nonzero on-time.
   assign start_ok_c = cmd.start
                       && (32'(cmd.start_idx) < NUM_LEDS)
                       && (cmd.duration_ms != '0);

   // One-hot load decode and per-channel timers.
   for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      assign load_c[gi] = start_ok_c && (cmd.start_idx == IDX_W'(gi));

      led_channel_timer #(
         .DUR_W (DUR_W)
      ) u_timer (
         .clk      (clk),
         .reset    (reset),
         .load     (load_c[gi]),
         .load_val (cmd.duration_ms),
         .clear    (clear[gi]),
         .tick     (tick),
         .led      (leds[gi]),
         .expired  (expired[gi])
      );
   end

endmodule : led_pulse_driver

// File: tb/tb_led_pulse_driver.sv
// Self-checking bench for led_pulse_driver (4 channels, 5-cycle tick).
module tb_led_pulse_driver;

   localparam int N  = 4;
   localparam int TC = 5;
   localparam int DW = 4;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] clear = '0;
   logic [N-1:0] leds;
   logic [N-1:0] expired;
   logic         tick;

   logic [2:0]   clear3 = '0;
   logic [2:0]   leds3;
   logic [2:0]   expired3;
   logic         tick3;

   led_pulse_driver_if #(.NUM_LEDS(N), .DUR_W(DW)) bus  ();
   led_pulse_driver_if #(.NUM_LEDS(3), .DUR_W(DW)) bus3 ();

   led_pulse_driver #(.NUM_LEDS(N), .TICK_COUNTS(TC), .DUR_W(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .cmd     (bus),
      .clear   (clear),
      .leds    (leds),
      .expired (expired),
      .tick    (tick)
   );

   // Three-channel instance: index 3 is representable but out of range.
   led_pulse_driver #(.NUM_LEDS(3), .TICK_COUNTS(TC), .DUR_W(DW)) dut3 (
      .clk     (clk),
      .reset   (reset),
      .cmd     (bus3),
      .clear   (clear3),
      .leds    (leds3),
      .expired (expired3),
      .tick    (tick3)
   );

   always #5 clk = ~clk;

   int errors  = 0;
   int checks  = 0;
   int exp3_cnt = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tick every TC cycles after reset, per-channel ms countdown.
   int       cyc = 0;
   bit       m_tick = 1'b0;
   bit [N-1:0] m_leds = '0;
   bit [N-1:0] m_exp  = '0;
   int       rem [N];

   always @(posedge clk) begin
      if (reset) begin
         cyc    = 0;
         m_tick = 1'b0;
         m_leds = '0;
         m_exp  = '0;
         for (int c = 0; c < N; c++) rem[c] = 0;
      end else begin
         cyc++;
         m_exp = '0;
         for (int c = 0; c < N; c++) begin
            if (bus.start && int'(bus.start_idx) == c && bus.duration_ms != 0)
               rem[c] = int'(bus.duration_ms);
            else if (clear[c])
               rem[c] = 0;
            else if (m_tick && rem[c] > 0) begin
               rem[c]--;
               if (rem[c] == 0) m_exp[c] = 1'b1;
            end
            m_leds[c] = (rem[c] != 0);
         end
         m_tick = (cyc % TC == 0);
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_leds", 32'(leds), 32'(m_leds));
         check("cyc_expired", 32'(expired), 32'(m_exp));
         check("cyc_tick", 32'(tick), 32'(m_tick));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (expired[3]) exp3_cnt++;
   endtask

   // Advance until the registered tick is high (consumed at the next edge).
   task automatic wait_tick();
      bit ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (tick) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_tick: got no tick, required one within 12 cycles");
      end
   endtask

   task automatic issue(input int idx, input int dur);
      bus.start       = 1'b1;
      bus.start_idx   = 2'(idx);
      bus.duration_ms = 4'(dur);
   endtask

   int on_time;
   bit off_seen;

   initial begin
      bus.start = 1'b0;  bus.start_idx = '0;  bus.duration_ms = '0;
      bus3.start = 1'b0; bus3.start_idx = '0; bus3.duration_ms = '0;

      // 1. Reset, then idle; first tick exactly TC cycles after release.
      step();
      chk_en = 1'b1;
      step();
      check("reset_leds", 32'(leds), 32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= TC; k++) begin
         step();
         check("first_tick_phase", 32'(tick), 32'(k == TC));
      end
      repeat (15) step();

      // 2. Natural expiry with a single one-cycle pulse.
      issue(2, 3);
      step();
      bus.start = 1'b0;
      check("start2_leds", 32'(leds), 32'b0100);
      on_time  = 1;
      off_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!leds[2]) begin
            off_seen = 1'b1;
            break;
         end
         on_time++;
      end
      check("start2_off_seen", 32'(off_seen), 32'd1);
      check("start2_on_time_ok", 32'(on_time >= 2*TC+1 && on_time <= 3*TC), 32'd1);
      check("start2_expired", 32'(expired), 32'b0100);
      step();
      check("start2_expired_once", 32'(expired), 32'd0);

      // 3. Early clear: LED off next cycle, no expiry.
      issue(1, 5);
      step();
      bus.start = 1'b0;
      wait_tick();
      wait_tick();
      step();
      check("ch1_lit_before_clear", 32'(leds), 32'b0010);
      clear = 4'b0010;
      step();
      clear = '0;
      check("clear1_leds", 32'(leds), 32'd0);
      check("clear1_no_expiry", 32'(expired), 32'd0);
      repeat (3) step();

      // 4a. Start + clear + tick on one cycle: load wins.
      wait_tick();
      issue(0, 2);
      clear = 4'b0001;
      step();
      bus.start = 1'b0;
      clear = '0;
      check("load_beats_clear", 32'(leds), 32'b0001);
      // 4b. Clear on the cycle of the 1->0 tick: no expiry.
      wait_tick();
      step();
      wait_tick();
      clear = 4'b0001;
      step();
      clear = '0;
      check("clear_beats_expiry_led", 32'(leds), 32'd0);
      check("clear_beats_expiry_exp", 32'(expired), 32'd0);
      repeat (2) step();

      // 5. Restart an active channel: one expiry for the restarted run only.
      exp3_cnt = 0;
      issue(3, 4);
      step();
      bus.start = 1'b0;
      wait_tick();
      step();
      wait_tick();
      step();
      issue(3, 2);
      step();
      bus.start = 1'b0;
      check("restart_lit", 32'(leds), 32'b1000);
      off_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (!leds[3]) begin
            off_seen = 1'b1;
            break;
         end
      end
      check("restart_off_seen", 32'(off_seen), 32'd1);
      repeat (3) step();
      check("restart_single_expiry", 32'(exp3_cnt), 32'd1);

      // 6. Ignored starts, then reset aborting active channels.
      issue(0, 0);
      step();
      bus.start = 1'b0;
      check("zero_dur_ignored", 32'(leds), 32'd0);
      bus3.start = 1'b1; bus3.start_idx = 2'd3; bus3.duration_ms = 4'd3;
      step();
      bus3.start = 1'b0;
      check("oor_ignored", 32'(leds3), 32'd0);
      step();
      check("oor_ignored_later", 32'({leds3, expired3}), 32'd0);
      bus3.start = 1'b1; bus3.start_idx = 2'd2; bus3.duration_ms = 4'd1;
      step();
      bus3.start = 1'b0;
      check("dut3_valid_start", 32'(leds3), 32'b100);

      issue(1, 5);
      step();
      issue(2, 5);
      step();
      bus.start = 1'b0;
      check("two_active", 32'(leds), 32'b0110);
      reset = 1'b1;
      step();
      check("reset_abort_leds", 32'(leds), 32'd0);
      check("reset_abort_expired", 32'(expired), 32'd0);
      reset = 1'b0;
      repeat (10) step();
      check("post_reset_idle", 32'(leds), 32'd0);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_led_pulse_driver
